// File: rtl/dense_mac_layer_seq.sv
// Sequential dense layer: M_OUTPUT parallel MAC lanes walk over N_INPUT inputs,
// then scale, add bias, saturate and optionally ReLU each lane into out.
module dense_mac_layer_seq #(
  parameter int N_INPUT  = 2,
  parameter int M_OUTPUT = 9,
  parameter int BITSIZE  = 16,
  parameter int FRAC     = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [N_INPUT*BITSIZE-1:0]             z,
  input  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0]    w,
  input  logic [M_OUTPUT*BITSIZE-1:0]            b,
  input  logic [1:0]                             act_mode,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [M_OUTPUT*BITSIZE-1:0]            out,
  output logic                                   busy
);

  localparam int ACCW = 2*BITSIZE + $clog2(N_INPUT) + 1;
  localparam int RW   = ACCW + 1;
  localparam int KW   = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_INPUT - 1);
  localparam logic signed [RW-1:0] SAT_MAX =
    {{(RW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN =
    {{(RW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            out_valid_q, out_valid_d;
  logic            accept, acc_en, fin_en;

  logic signed [BITSIZE-1:0] z_q [N_INPUT];
  logic signed [BITSIZE-1:0] w_q [M_OUTPUT][N_INPUT];
  logic signed [BITSIZE-1:0] b_q [M_OUTPUT];
  logic [1:0]                mode_q;
  logic signed [BITSIZE-1:0] z_k;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    accept      = 1'b0;
    acc_en      = 1'b0;
    fin_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          k_d     = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_en = 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_FIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_FIN: begin
        fin_en      = 1'b1;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operands are captured once per accept so upstream may change them freely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 2'd0;
      for (int i = 0; i < N_INPUT; i++) z_q[i] <= '0;
      for (int j = 0; j < M_OUTPUT; j++) begin
        b_q[j] <= '0;
        for (int i = 0; i < N_INPUT; i++) w_q[j][i] <= '0;
      end
    end else if (accept) begin
      mode_q <= act_mode;
      for (int i = 0; i < N_INPUT; i++) z_q[i] <= z[i*BITSIZE +: BITSIZE];
      for (int j = 0; j < M_OUTPUT; j++) begin
        b_q[j] <= b[j*BITSIZE +: BITSIZE];
        for (int i = 0; i < N_INPUT; i++)
          w_q[j][i] <= w[(j*N_INPUT+i)*BITSIZE +: BITSIZE];
      end
    end
  end

  assign z_k = z_q[k_q];

  for (genvar gi = 0; gi < M_OUTPUT; gi++) begin : g_lane
    logic signed [BITSIZE-1:0]   w_k;
    logic signed [2*BITSIZE-1:0] prod;
    logic signed [ACCW-1:0]      acc_q, acc_d, acc_shr;
    logic signed [RW-1:0]        r_full;
    logic signed [BITSIZE-1:0]   sat, out_d, out_q;

    assign w_k  = w_q[gi][k_q];
    // Both factors widened first so the full product is formed at 2*BITSIZE.
    assign prod = $signed({{BITSIZE{z_k[BITSIZE-1]}}, z_k})
                * $signed({{BITSIZE{w_k[BITSIZE-1]}}, w_k});

    always_comb begin
      acc_d = acc_q;
      if (accept)
        acc_d = '0;
      else if (acc_en)
        acc_d = acc_q + {{(ACCW-2*BITSIZE){prod[2*BITSIZE-1]}}, prod};
    end

    assign acc_shr = acc_q >>> FRAC;
    assign r_full  = {acc_shr[ACCW-1], acc_shr}
                   + {{(RW-BITSIZE){b_q[gi][BITSIZE-1]}}, b_q[gi]};

    always_comb begin
      if (r_full > SAT_MAX)
        sat = {1'b0, {(BITSIZE-1){1'b1}}};
      else if (r_full < SAT_MIN)
        sat = {1'b1, {(BITSIZE-1){1'b0}}};
      else
        sat = r_full[BITSIZE-1:0];
      out_d = sat;
      if (mode_q == 2'd1 && sat[BITSIZE-1])
        out_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc_q <= '0;
        out_q <= '0;
      end else begin
        acc_q <= acc_d;
        if (fin_en) out_q <= out_d;
      end
    end

    assign out[gi*BITSIZE +: BITSIZE] = out_q;
  end

endmodule

// File: doc/dense_mac_layer_seq.md
DENSE_MAC_LAYER_SEQ -- requirements
Module: dense_mac_layer_seq

Interface
REQ-001 SHALL have parameter N_INPUT, default 2: number of layer inputs; legal range 1..64.
REQ-002 SHALL have parameter M_OUTPUT, default 9: number of layer outputs / parallel MAC lanes; legal range 1..64.
REQ-003 SHALL have parameter BITSIZE, default 16: signed two's-complement word width of z, w, b and out.
REQ-004 SHALL have parameter FRAC, default 8: fractional bits of the fixed-point format; legal range 0..BITSIZE-1.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  z/w/b/act_mode valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a new vector.
REQ-009 SHALL have port z  input  N_INPUT*BITSIZE  inputs; z_i = z[i*BITSIZE +: BITSIZE].
REQ-010 SHALL have port w  input  N_INPUT*M_OUTPUT*BITSIZE  weights; w_ji = w[(j*N_INPUT+i)*BITSIZE +: BITSIZE].
REQ-011 SHALL have port b  input  M_OUTPUT*BITSIZE  biases; b_j = b[j*BITSIZE +: BITSIZE].
REQ-012 SHALL have port act_mode  input  2  0 = linear, 1 = ReLU, 2 and 3 = linear.
REQ-013 SHALL have port out_valid  output  1  out holds a completed result.
REQ-014 SHALL have port out_ready  input  1  downstream accepts out.
REQ-015 SHALL have port out  output  M_OUTPUT*BITSIZE  results; out_j = out[j*BITSIZE +: BITSIZE].
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACC, FIN, DONE; in_ready = (state==IDLE), combinational from state.
REQ-018 SHALL accept on a rising edge with in_valid && in_ready: register z, w, b and act_mode; clear all accumulators; load index counter k=0; go to ACC.
REQ-019 SHALL ignore z/w/b/act_mode changes after acceptance until the next acceptance.
REQ-020 SHALL, in ACC on each edge, add the full-precision 2*BITSIZE-bit product z_k*w_jk, sign-extended, to accumulator j for every j in parallel, then increment k.
REQ-021 SHALL size each accumulator at 2*BITSIZE+clog2(N_INPUT)+1 bits so that no intermediate overflow occurs.
REQ-022 SHALL leave ACC for FIN on the edge that processes k = N_INPUT-1; N_INPUT=1 gives exactly one ACC cycle.
REQ-023 SHALL, on the FIN edge, compute r_j = (acc_j >>> FRAC) + sign-extended b_j, using an arithmetic shift that truncates toward minus infinity.
REQ-024 SHALL, on the same FIN edge, saturate r_j to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1], apply ReLU (negative -> 0) if act_mode==1, register the result to out_j, set out_valid=1, and go to DONE.
REQ-025 SHALL, for latency, assert out_valid after the (N_INPUT+1)th rising edge following the accept edge.
REQ-026 SHALL, in DONE, hold out and out_valid stable while out_ready=0, with no timeout.
REQ-027 SHALL, on an edge in DONE with out_ready=1, clear out_valid and go to IDLE; out keeps its last value; the earliest next accept is the following edge.
REQ-028 SHALL ignore out_ready in every state except DONE, and ignore in_valid in every state except IDLE.

Reset
REQ-029 SHALL, while reset=1 at any time including mid-ACC or in DONE, force state=IDLE, k=0, all accumulators to 0, out to all zeros and out_valid=0.
REQ-030 SHALL have in_ready=1 and busy=0 while reset=1 and after reset deasserts, and SHALL NOT produce a partial result from an interrupted computation.

Verification
REQ-031 SHALL pass basic MAC: N=2, M=3, FRAC=8, z=(0x0100,0x0200), w_0=(0x0100,0x0080), b_0=0x0080, act_mode=0 -> out_0=0x0280, out_valid after the 3rd edge following accept.
REQ-032 SHALL pass saturation: z_i=0x7FFF, w_ji=0x7FFF, b=0x7FFF -> out_j=0x7FFF; with all w_ji=0x8000 and z_i=0x7FFF -> out_j=0x8000.
REQ-033 SHALL pass ReLU: an input set giving r_0=-0x0140 -> out_0=0x0000 with act_mode=1; the same input with act_mode=0 -> out_0=0xFEC0.
REQ-034 SHALL pass backpressure: hold out_ready=0 for 5 cycles in DONE -> out and out_valid stable, in_ready=0, a pending in_valid is not accepted; on release, IDLE follows on the next edge.
REQ-035 SHALL pass mid-operation reset: N=4, assert reset during the 2nd ACC cycle -> out=0, out_valid=0, in_ready=1; the next vector gives a correct result.
REQ-036 SHALL pass back-to-back: 8 random vectors with in_valid held high and out_ready=1 -> results match the reference model, with one accept every N_INPUT+3 cycles.
